// File: rtl/decode_pipe_stage.sv
// Decode pipeline stage: builds the immediate and captures register operands.
// Results go into a small FIFO that presents its head to the execute stage.
module decode_pipe_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5,
    parameter int BUF_DEPTH      = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [ADDR_WIDTH-1:0]         pc_i,
    input  logic [31:0]                   instr_i,
    output logic [REGISTER_WIDTH-1:0]     rs1_o,
    output logic [REGISTER_WIDTH-1:0]     rs2_o,
    input  logic [DATA_WIDTH-1:0]         rs1_data_i,
    input  logic [DATA_WIDTH-1:0]         rs2_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [ADDR_WIDTH-1:0]         out_pc_o,
    output logic [31:0]                   out_instr_o,
    output logic [DATA_WIDTH-1:0]         out_rs1_data_o,
    output logic [DATA_WIDTH-1:0]         out_rs2_data_o,
    output logic [DATA_WIDTH-1:0]         out_imm_o,
    output logic [$clog2(BUF_DEPTH):0]    occupancy_o,
    output logic [CNT_WIDTH-1:0]          stall_cnt_o
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Sign-extended immediate for the RV32 base formats; unknown opcodes yield zero.
    function automatic logic [DATA_WIDTH-1:0] decode_imm(input logic [31:0] instr);
        logic [31:0] imm32;
        case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            7'b0100011:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            7'b1100011:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm32 = {instr[31:12], 12'h000};
            7'b1101111:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm32 = 32'h0000_0000;
        endcase
        return DATA_WIDTH'($signed(imm32));
    endfunction

    logic [ADDR_WIDTH-1:0] pc_mem_r    [BUF_DEPTH];
    logic [31:0]           instr_mem_r [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] rs1_mem_r   [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] rs2_mem_r   [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] imm_mem_r   [BUF_DEPTH];

    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [OCC_W-1:0]     occ_r;
    logic [CNT_WIDTH-1:0] stall_cnt_r;

    logic in_ready_s;
    logic out_valid_s;
    logic push_s;
    logic pop_s;
    logic stall_s;

    // Handshake decode; ready depends only on stored occupancy, flush and reset.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        stall_s     = 1'b0;
        if (rst_i) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = (occ_r < OCC_W'(BUF_DEPTH)) && !flush_i;
        end
        out_valid_s = (occ_r != '0);
        push_s      = in_valid_i && in_ready_s;
        pop_s       = out_valid_s && out_ready_i && !flush_i;
        stall_s     = out_valid_s && !out_ready_i && !flush_i;
    end

    // Queue pointers and occupancy; flush empties the queue and ignores any pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
        end else if (flush_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Saturating count of cycles the head waited on downstream.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_r <= '0;
        end else if (stall_s && (stall_cnt_r != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_WIDTH'(1);
        end
    end

    // Entry storage; left unreset since contents are only meaningful while valid.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]    <= pc_i;
            instr_mem_r[wr_ptr_r] <= instr_i;
            rs1_mem_r[wr_ptr_r]   <= rs1_data_i;
            rs2_mem_r[wr_ptr_r]   <= rs2_data_i;
            imm_mem_r[wr_ptr_r]   <= decode_imm(instr_i);
        end
    end

    assign rs1_o          = REGISTER_WIDTH'(instr_i[19:15]);
    assign rs2_o          = REGISTER_WIDTH'(instr_i[24:20]);
    assign in_ready_o     = in_ready_s;
    assign out_valid_o    = out_valid_s;
    assign out_pc_o       = pc_mem_r[rd_ptr_r];
    assign out_instr_o    = instr_mem_r[rd_ptr_r];
    assign out_rs1_data_o = rs1_mem_r[rd_ptr_r];
    assign out_rs2_data_o = rs2_mem_r[rd_ptr_r];
    assign out_imm_o      = imm_mem_r[rd_ptr_r];
    assign occupancy_o    = occ_r;
    assign stall_cnt_o    = stall_cnt_r;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Bench for decode_pipe_stage: directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_decode_pipe_stage;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;
    localparam int BD = 2;
    localparam int CW = 4;
    localparam int STALL_MAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [AW-1:0] pc_i;
    logic [31:0]   instr_i;
    logic [RW-1:0] rs1_o;
    logic [RW-1:0] rs2_o;
    logic [DW-1:0] rs1_data_i;
    logic [DW-1:0] rs2_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [AW-1:0] out_pc_o;
    logic [31:0]   out_instr_o;
    logic [DW-1:0] out_rs1_data_o;
    logic [DW-1:0] out_rs2_data_o;
    logic [DW-1:0] out_imm_o;
    logic [$clog2(BD):0] occupancy_o;
    logic [CW-1:0] stall_cnt_o;

    decode_pipe_stage #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REGISTER_WIDTH(RW),
        .BUF_DEPTH(BD), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .instr_i(instr_i), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .out_instr_o(out_instr_o),
        .out_rs1_data_o(out_rs1_data_o), .out_rs2_data_o(out_rs2_data_o),
        .out_imm_o(out_imm_o), .occupancy_o(occupancy_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } ent_t;

    ent_t        q[$];
    int          stall_m;
    logic [31:0] regs[32];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Immediate rebuilt arithmetically from the field weights of each format.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int v;
        v = $signed(ins);
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: return v >>> 20;
            7'h23: return ((v >>> 25) * 32) + int'(ins[11:7]);
            7'h63: return ((v >>> 31) * 4096) + int'(ins[7]) * 2048
                          + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            7'h37, 7'h17: return ins & 32'hFFFF_F000;
            7'h6F: return ((v >>> 31) * 1048576) + int'(ins[19:12]) * 4096
                          + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_state();
        check_val("occupancy", 64'(occupancy_o), 64'(q.size()));
        check_val("out_valid", 64'(out_valid_o), 64'(q.size() != 0));
        check_val("stall_cnt", 64'(stall_cnt_o), 64'(stall_m));
        if (q.size() != 0) begin
            check_val("head_pc", 64'(out_pc_o), 64'(q[0].pc));
            check_val("head_instr", 64'(out_instr_o), 64'(q[0].instr));
            check_val("head_rs1", 64'(out_rs1_data_o), 64'(q[0].a));
            check_val("head_rs2", 64'(out_rs2_data_o), 64'(q[0].b));
            check_val("head_imm", 64'(out_imm_o), 64'(q[0].imm));
        end
    endtask

    // One clock: drive at negedge, predict, apply at posedge, compare at next negedge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic fl);
        bit   push, pop, stl;
        ent_t e;
        in_valid_i  = v;
        pc_i        = pc;
        instr_i     = ins;
        out_ready_i = rdy;
        flush_i     = fl;
        rs1_data_i  = regs[ins[19:15]];
        rs2_data_i  = regs[ins[24:20]];
        #1;
        check_val("in_ready", 64'(in_ready_o), 64'((q.size() < BD) && !fl));
        check_val("rs1_idx", 64'(rs1_o), 64'(ins[19:15]));
        check_val("rs2_idx", 64'(rs2_o), 64'(ins[24:20]));
        push = v && (q.size() < BD) && !fl;
        pop  = (q.size() != 0) && rdy && !fl;
        stl  = (q.size() != 0) && !rdy && !fl;
        e.pc    = pc;
        e.instr = ins;
        e.a     = regs[ins[19:15]];
        e.b     = regs[ins[24:20]];
        e.imm   = ref_imm(ins);
        @(posedge clk_i);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
        end
        if (stl && stall_m < STALL_MAX) stall_m++;
        @(negedge clk_i);
        check_state();
    endtask

    logic [31:0] imm_vec_in  [6] = '{32'h00A0_0093, 32'hFE11_2E23, 32'hFE00_0EE3,
                                     32'h1234_52B7, 32'h0000_006F, 32'h0000_0033};
    logic [31:0] imm_vec_exp [6] = '{32'h0000_000A, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
                                     32'h1234_5000, 32'h0000_0000, 32'h0000_0000};
    logic [6:0]  opcodes [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63,
                                  7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

    initial begin
        logic [31:0] r;
        logic [31:0] A, B, C;
        for (int i = 0; i < 32; i++) regs[i] = $urandom();
        stall_m     = 0;
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        pc_i        = '0;
        instr_i     = '0;
        rs1_data_i  = '0;
        rs2_data_i  = '0;
        #1;
        check_val("rst_in_ready", 64'(in_ready_o), 64'(0));
        check_val("rst_out_valid", 64'(out_valid_o), 64'(0));
        check_val("rst_occupancy", 64'(occupancy_o), 64'(0));
        check_val("rst_stall", 64'(stall_cnt_o), 64'(0));
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_val("post_rst_in_ready", 64'(in_ready_o), 64'(1));
        @(negedge clk_i);

        // Single pass-through and immediate sweep with downstream always ready.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h100 + 32'(i * 4), imm_vec_in[i], 1'b1, 1'b0);
            check_val("imm_vector", 64'(out_imm_o), 64'(imm_vec_exp[i]));
            check_val("vec_pc", 64'(out_pc_o), 64'(32'h100 + 32'(i * 4)));
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Backpressure: A and B queue, C held; then full-with-pop and push+pop.
        A = 32'h0010_8113; B = 32'h0020_A023; C = 32'h0031_8463;
        step(1'b1, 32'h200, A, 1'b0, 1'b0);
        step(1'b1, 32'h204, B, 1'b0, 1'b0);
        step(1'b1, 32'h208, C, 1'b0, 1'b0);
        step(1'b1, 32'h208, C, 1'b0, 1'b0);
        check_val("bp_occupancy", 64'(occupancy_o), 64'(2));
        step(1'b1, 32'h208, C, 1'b1, 1'b0);
        check_val("full_pop_head", 64'(out_instr_o), 64'(B));
        step(1'b1, 32'h208, C, 1'b1, 1'b0);
        check_val("pushpop_occ", 64'(occupancy_o), 64'(1));
        check_val("fifo_c", 64'(out_instr_o), 64'(C));
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with a full queue and a valid incoming instruction.
        step(1'b1, 32'h300, A, 1'b0, 1'b0);
        step(1'b1, 32'h304, B, 1'b0, 1'b0);
        step(1'b1, 32'h308, C, 1'b0, 1'b1);
        check_val("flush_valid", 64'(out_valid_o), 64'(0));
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset pulse between edges with two entries queued.
        step(1'b1, 32'h400, A, 1'b0, 1'b0);
        step(1'b1, 32'h404, B, 1'b0, 1'b0);
        in_valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        check_val("async_rst_valid", 64'(out_valid_o), 64'(0));
        check_val("async_rst_ready", 64'(in_ready_o), 64'(0));
        check_val("async_rst_occ", 64'(occupancy_o), 64'(0));
        #1 rst_i = 1'b0;
        q.delete();
        stall_m = 0;
        @(negedge clk_i);
        check_state();

        // Stall counter saturation.
        step(1'b1, 32'h500, A, 1'b0, 1'b0);
        for (int i = 0; i < STALL_MAX + 4; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_val("stall_sat", 64'(stall_cnt_o), 64'(STALL_MAX));
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r = $urandom();
            r[6:0] = opcodes[$urandom_range(0, 9)];
            step($urandom_range(0, 3) != 0, $urandom(), r,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
